bru_resolver: RTL
=================

BRU_RESOLVER -- requirements
Module: bru_resolver

Interface
REQ-001 SHALL have parameter: UPD_EN, 1, enables the predictor-update outputs (0 ties s_upd_valid_o low).
REQ-002 SHALL have port: s_clk_i  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port: s_resetn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: s_ex_valid_i  in  1  EX holds a BRU/jump instruction with final ALU result.
REQ-005 SHALL have port: s_ex_result_i  in  32  ALU word {target[30:0], cond}.
REQ-006 SHALL have port: s_ex_jump_i  in  1  unconditional jump, cond ignored, always taken.
REQ-007 SHALL have port: s_ex_pred_taken_i  in  1  fetch-time prediction taken.
REQ-008 SHALL have port: s_ex_pred_tadd_i  in  31  predicted target, halfword address.
REQ-009 SHALL have port: s_ex_npc_i  in  31  fall-through address, halfword address.
REQ-010 SHALL have port: s_ma_stall_i  in  1  MA stage stalled, no capture.
REQ-011 SHALL have port: s_flush_i  in  1  pipeline flush, kills MA content.
REQ-012 SHALL have port: s_fe_ready_i  in  1  fetch accepts redirect this cycle.
REQ-013 SHALL have port: s_ma_taken_o  out  1  MA instruction performs a transfer of control (TOC).
REQ-014 SHALL have port: s_ma_tadd_o  out  31  MA resolved target, fed back to the ALU.
REQ-015 SHALL have port: s_redirect_valid_o / s_redirect_addr_o  out  1/31  redirect request and address.
REQ-016 SHALL have port: s_upd_valid_o / s_upd_taken_o  out  1/1  one-shot predictor update.
REQ-017 SHALL have port: s_busy_o  out  1  stalls EX while a redirect is pending.

Function
REQ-018 SHALL capture on an edge where s_ex_valid_i & ~s_ma_stall_i & ~s_busy_o & ~s_flush_i: taken = s_ex_jump_i | s_ex_result_i[0]; tadd = s_ex_result_i[31:1].
REQ-019 SHALL register mispredict = (taken != pred_taken) | (taken & tadd != pred_tadd) at capture.
REQ-020 SHALL use FSM states IDLE, VALID and REDIRECT; capture without mispredict -> VALID; capture with mispredict -> REDIRECT; VALID with no capture -> IDLE; VALID with a new capture re-evaluates per REQ-018/019.
REQ-021 SHALL drive s_ma_taken_o = (state != IDLE) & taken_q, and s_ma_tadd_o = tadd_q whenever taken_q is set, else 0.
REQ-022 SHALL in REDIRECT hold s_redirect_valid_o=1 and s_redirect_addr_o = taken_q ? tadd_q : npc_q stable until s_fe_ready_i; acceptance -> IDLE the next cycle.
REQ-023 SHALL drive s_busy_o = (state == REDIRECT) & ~s_fe_ready_i, so a same-cycle accept does not stall EX.
REQ-024 SHALL pulse s_upd_valid_o for exactly one cycle, the cycle after capture, with s_upd_taken_o = taken_q; it SHALL NOT pulse for a flushed capture.
REQ-025 SHALL give s_flush_i priority over everything: next state IDLE, pending redirect dropped, no update pulse, no capture that edge.
REQ-026 SHALL hold all registers while s_ma_stall_i is high and no flush is present; a REDIRECT handshake still completes during a stall.
REQ-027 SHALL compute address compares at full 31 bits with no wrap handling; 0x7FFFFFFF is a legal target.
REQ-028 SHALL have 1-cycle latency from capture to s_ma_taken_o and s_redirect_valid_o.

Reset
REQ-029 SHALL on s_resetn_i low set state IDLE and all outputs 0 immediately; reset mid-REDIRECT drops the request with no update pulse.

Structure
REQ-030 SHALL add a bru_state enum (IDLE, VALID, REDIRECT) to p_hardisc; it needs no other new constants.
REQ-031 SHALL contain no sub-modules except an optional mispredict comparator, bru_cmp.

Verification
REQ-032 SHALL cover: result 0x00001001 (tadd 0x800, cond 1), pred_taken=1, pred_tadd 0x800 -> VALID, ma_taken=1, no redirect, upd_taken=1.
REQ-033 SHALL cover: cond 0, pred_taken=1, npc 0x104 -> redirect_addr 0x104; fe_ready low for 3 cycles -> busy=1 and addr stable for those cycles; accept -> IDLE.
REQ-034 SHALL cover: jump=1, result 0x00000200, pred_tadd 0x080 -> redirect_addr 0x100.
REQ-035 SHALL cover: flush asserted in the REDIRECT cycle -> redirect_valid=0 next cycle, no upd pulse.
REQ-036 SHALL cover: back-to-back captures under stall toggling -> exactly one upd pulse per non-flushed capture.
REQ-037 SHALL cover: reset asserted asynchronously mid-REDIRECT -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/bru_resolver_pkg.sv
// Shared types for the hardisc pipeline. This slice adds the state type of
// the branch resolution unit that sits in the MA stage.
package p_hardisc;

  // IDLE: MA holds no BRU instruction.
  // VALID: MA holds a correctly predicted BRU instruction.
  // REDIRECT: MA holds a mispredicted one and a fetch redirect is pending.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    REDIRECT = 2'd2
  } bru_state;

endpackage

// File: rtl/bru_resolver_if.sv
// Redirect handshake between the branch resolver (master) and fetch (slave).
//   redirect_valid : resolver requests a fetch redirect
//   redirect_addr  : halfword address to fetch from, held until accepted
//   fe_ready       : fetch accepts the redirect this cycle
interface bru_resolver_if;

  logic        redirect_valid;
  logic [30:0] redirect_addr;
  logic        fe_ready;

  modport master (
    output redirect_valid,
    output redirect_addr,
    input  fe_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_addr,
    output fe_ready
  );

endinterface

// File: rtl/bru_resolver_cmp.sv
// Mispredict comparator: flags a wrong direction, or a wrong target on a taken
// transfer. Addresses compare at the full 31 bits, no wrap handling.
//   i_taken / i_tadd           : resolved direction and target
//   i_pred_taken / i_pred_tadd : fetch-time prediction
//   o_mispredict               : prediction was wrong
module bru_cmp (
  input  logic        i_taken,
  input  logic [30:0] i_tadd,
  input  logic        i_pred_taken,
  input  logic [30:0] i_pred_tadd,
  output logic        o_mispredict
);

  assign o_mispredict = (i_taken != i_pred_taken) |
                        (i_taken & (i_tadd != i_pred_tadd));

endmodule

// File: rtl/bru_resolver.sv
// Branch resolution unit in the MA stage. Captures the resolved BRU/jump
// result from EX, compares it with the fetch-time prediction, requests a fetch
// redirect on mispredict and emits a one-shot predictor update.
//   s_clk_i, s_resetn_i       : clock, asynchronous active-low reset
//   s_ex_*                    : EX-stage instruction, ALU result and prediction
//   s_ma_stall_i, s_flush_i   : MA stall and pipeline flush
//   redir (master)            : redirect request/address, fetch ready
//   s_ma_taken_o, s_ma_tadd_o : MA transfer of control and resolved target
//   s_upd_valid_o/_taken_o    : predictor update pulse
//   s_busy_o                  : stalls EX while a redirect is pending
module bru_resolver
  import p_hardisc::*;
#(
  parameter bit UPD_EN = 1'b1
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_ex_valid_i,
  input  logic [31:0]     s_ex_result_i,
  input  logic            s_ex_jump_i,
  input  logic            s_ex_pred_taken_i,
  input  logic [30:0]     s_ex_pred_tadd_i,
  input  logic [30:0]     s_ex_npc_i,
  input  logic            s_ma_stall_i,
  input  logic            s_flush_i,
  bru_resolver_if.master  redir,
  output logic            s_ma_taken_o,
  output logic [30:0]     s_ma_tadd_o,
  output logic            s_upd_valid_o,
  output logic            s_upd_taken_o,
  output logic            s_busy_o
);

  bru_state    r_state;
  logic        r_taken;
  logic [30:0] r_tadd;
  logic [30:0] r_npc;
  logic        r_upd;

  bru_state    w_state_nxt;
  logic        w_taken_nxt;
  logic [30:0] w_tadd_nxt;
  logic [30:0] w_npc_nxt;
  logic        w_upd_nxt;

  logic        w_busy;
  logic        w_capture;
  logic        w_taken;
  logic [30:0] w_tadd;
  logic        w_mispredict;

  // An accepting fetch in the same cycle frees EX, so busy drops immediately.
  assign w_busy    = (r_state == REDIRECT) & ~redir.fe_ready;
  assign w_capture = s_ex_valid_i & ~s_ma_stall_i & ~w_busy & ~s_flush_i;
  assign w_taken   = s_ex_jump_i | s_ex_result_i[0];
  assign w_tadd    = s_ex_result_i[31:1];

  bru_cmp u_cmp (
    .i_taken      (w_taken),
    .i_tadd       (w_tadd),
    .i_pred_taken (s_ex_pred_taken_i),
    .i_pred_tadd  (s_ex_pred_tadd_i),
    .o_mispredict (w_mispredict)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_taken_nxt = r_taken;
    w_tadd_nxt  = r_tadd;
    w_npc_nxt   = r_npc;
    w_upd_nxt   = 1'b0;
    if (s_flush_i) begin
      // Flush kills the MA content, including any pending redirect.
      w_state_nxt = IDLE;
      w_taken_nxt = 1'b0;
    end else if (w_capture) begin
      w_state_nxt = w_mispredict ? REDIRECT : VALID;
      w_taken_nxt = w_taken;
      w_tadd_nxt  = w_tadd;
      w_npc_nxt   = s_ex_npc_i;
      w_upd_nxt   = 1'b1;
    end else begin
      case (r_state)
        VALID:    if (!s_ma_stall_i) w_state_nxt = IDLE;
        // The handshake completes even while MA is stalled.
        REDIRECT: if (redir.fe_ready) w_state_nxt = IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_state <= IDLE;
      r_taken <= 1'b0;
      r_tadd  <= '0;
      r_npc   <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_taken <= w_taken_nxt;
      r_tadd  <= w_tadd_nxt;
      r_npc   <= w_npc_nxt;
      r_upd   <= w_upd_nxt;
    end
  end

  assign s_ma_taken_o         = (r_state != IDLE) & r_taken;
  assign s_ma_tadd_o          = r_taken ? r_tadd : '0;
  assign redir.redirect_valid = (r_state == REDIRECT);
  assign redir.redirect_addr  = (r_state == REDIRECT) ? (r_taken ? r_tadd : r_npc) : '0;
  assign s_busy_o             = w_busy;
  // A flush during the update cycle means the instruction never retires.
  assign s_upd_valid_o        = UPD_EN & r_upd & ~s_flush_i;
  assign s_upd_taken_o        = UPD_EN & r_upd & ~s_flush_i & r_taken;

endmodule
